// File: rtl/fetch_ctrl_pkg.sv
// Shared definitions for the fetch controller: FSM state type and default widths/reset PC.
package fetch_ctrl_pkg;

   localparam int PC_W   = 6;
   localparam int PC_RST = 0;
   localparam int CNT_W  = 8;

   typedef enum logic [1:0] {
      ST_RUN  = 2'd0,
      ST_HOLD = 2'd1,
      ST_HALT = 2'd2
   } fetch_state_e;

endpackage

// File: rtl/fetch_redirect_buf.sv
// Pending-redirect register: captures a redirect that arrives while the front end is frozen
// and hands it back once the stall releases. A branch outranks a jump, pending or coincident.
module fetch_redirect_buf #(
   parameter int PC_W = 6,
   parameter logic [PC_W-1:0] PC_RST_V = '0
) (
   input  logic            clck,
   input  logic            rst,
   input  logic            capture_en,
   input  logic            br_taken,
   input  logic [PC_W-1:0] br_target,
   input  logic            jump,
   input  logic [PC_W-1:0] jump_target,
   input  logic            consume,
   output logic            pend_valid,
   output logic [PC_W-1:0] pend_target,
   output logic            accept
);

   logic pend_br;
   logic accept_br;
   logic accept_jump;

   assign accept_br   = capture_en & br_taken;
   assign accept_jump = capture_en & jump & ~br_taken & ~(pend_valid & pend_br);
   assign accept      = accept_br | accept_jump;

   always_ff @(posedge clck) begin
      if (rst) begin
         pend_valid  <= 1'b0;
         pend_target <= PC_RST_V;
         pend_br     <= 1'b0;
      end else if (accept_br) begin
         pend_valid  <= 1'b1;
         pend_target <= br_target;
         pend_br     <= 1'b1;
      end else if (accept_jump) begin
         pend_valid  <= 1'b1;
         pend_target <= jump_target;
         pend_br     <= 1'b0;
      end else if (consume) begin
         pend_valid  <= 1'b0;
         pend_br     <= 1'b0;
      end
   end

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch-stage PC and pipeline-register control (RUN/HOLD/HALT). Optional performance
// counters stall_cnt/flush_cnt are built when FETCH_CTRL_PERF_EN is defined.
module fetch_ctrl #(
   parameter int PC_W   = fetch_ctrl_pkg::PC_W,
   parameter int PC_RST = fetch_ctrl_pkg::PC_RST,
   parameter int CNT_W  = fetch_ctrl_pkg::CNT_W
) (
   input  logic            clck,
   input  logic            rst,
   input  logic [PC_W-1:0] pc_cur,
   input  logic            load_use,
   input  logic            ext_stall,
   input  logic            jump,
   input  logic [PC_W-1:0] jump_target,
   input  logic            br_taken,
   input  logic [PC_W-1:0] br_target,
   input  logic            halt_req,
   input  logic            resume,
   output logic [PC_W-1:0] pc_next,
   output logic            pc_write,
   output logic            if_id_write,
   output logic            if_id_flush,
   output logic            id_ex_bubble,
   output logic            halted,
   output logic [1:0]      state_dbg
`ifdef FETCH_CTRL_PERF_EN
   ,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
`endif
);

   import fetch_ctrl_pkg::*;

   localparam logic [PC_W-1:0] PC_RST_V = PC_W'(PC_RST);

   fetch_state_e    state_q;
   logic            capture_en;
   logic            consume;
   logic            accept;
   logic            pend_valid;
   logic [PC_W-1:0] pend_target;
   logic [PC_W-1:0] pc_inc;
   logic            go_halt;

   assign pc_inc    = pc_cur + PC_W'(1);
   assign state_dbg = state_q;
   assign go_halt   = halt_req & ~br_taken & ~jump & ~load_use;

   fetch_redirect_buf #(
      .PC_W     (PC_W),
      .PC_RST_V (PC_RST_V)
   ) u_redirect_buf (
      .clck        (clck),
      .rst         (rst),
      .capture_en  (capture_en),
      .br_taken    (br_taken),
      .br_target   (br_target),
      .jump        (jump),
      .jump_target (jump_target),
      .consume     (consume),
      .pend_valid  (pend_valid),
      .pend_target (pend_target),
      .accept      (accept)
   );

   always_ff @(posedge clck) begin
      if (rst) begin
         state_q <= ST_RUN;
      end else begin
         case (state_q)
            ST_RUN: begin
               if (ext_stall)    state_q <= ST_HOLD;
               else if (go_halt) state_q <= ST_HALT;
            end
            ST_HOLD: begin
               if (!ext_stall) state_q <= (!pend_valid && go_halt) ? ST_HALT : ST_RUN;
            end
            ST_HALT: begin
               if (resume) state_q <= ST_RUN;
            end
            default: state_q <= ST_RUN;
         endcase
      end
   end

   always_comb begin
      pc_next      = pc_cur;
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      if_id_flush  = 1'b0;
      id_ex_bubble = 1'b0;
      halted       = 1'b0;
      capture_en   = 1'b0;
      consume      = 1'b0;
      if (rst) begin
         pc_next      = PC_RST_V;
         if_id_flush  = 1'b1;
         id_ex_bubble = 1'b1;
      end else if (state_q == ST_HALT) begin
         halted = 1'b1;
      end else if (ext_stall) begin
         // Front end frozen: any redirect is parked in the buffer, wrong-path fetch flushed.
         id_ex_bubble = 1'b1;
         capture_en   = 1'b1;
         if_id_flush  = accept;
      end else if (state_q == ST_HOLD && pend_valid) begin
         // Release cycle replays the parked redirect; other events this cycle are not acted on.
         pc_next     = pend_target;
         pc_write    = 1'b1;
         if_id_write = 1'b1;
         consume     = 1'b1;
      end else if (br_taken) begin
         pc_next      = br_target;
         pc_write     = 1'b1;
         if_id_write  = 1'b1;
         if_id_flush  = 1'b1;
         id_ex_bubble = 1'b1;
      end else if (jump) begin
         pc_next     = jump_target;
         pc_write    = 1'b1;
         if_id_write = 1'b1;
         if_id_flush = 1'b1;
      end else if (load_use) begin
         id_ex_bubble = 1'b1;
      end else if (!halt_req) begin
         pc_next     = pc_inc;
         pc_write    = 1'b1;
         if_id_write = 1'b1;
      end
   end

`ifdef FETCH_CTRL_PERF_EN
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   always_ff @(posedge clck) begin
      if (rst) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         if (!pc_write && !halted && stall_cnt != CNT_MAX) stall_cnt <= stall_cnt + CNT_W'(1);
         if (if_id_flush && flush_cnt != CNT_MAX)          flush_cnt <= flush_cnt + CNT_W'(1);
      end
   end
`endif

endmodule
